// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared types and helpers for the 1-to-N packet router.
//                Holds the FSM state encoding, header field width helpers
//                and the default stale-FIFO flush threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT = 30;

    // Width of the address field in the header byte.
    function automatic int addr_w_f(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Width of the LEN field, i.e. everything above the address bits.
    function automatic int len_w_f(input int data_w, input int num_ch);
        return data_w - addr_w_f(num_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_1xn_if.sv
`default_nettype none
// ============================================================================
//  Module      : router_1xn_if
//  Description : Source and destination side signals of the 1-to-N router.
//                master : packet source / destination agents (drives
//                         data_in, pkt_vld, read_eb)
//                slave  : the router itself
//                Ports  : data_in, pkt_vld, busy, error, drop, read_eb,
//                         data_out (channel c at [c*DATA_W +: DATA_W]), vld_out
//  Revision    : 1.0 - initial release
// ============================================================================
interface router_1xn_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3
);
    logic [DATA_W-1:0]        data_in;
    logic                     pkt_vld;
    logic                     busy;
    logic                     error;
    logic                     drop;
    logic [NUM_CH-1:0]        read_eb;
    logic [NUM_CH*DATA_W-1:0] data_out;
    logic [NUM_CH-1:0]        vld_out;

    modport master (
        output data_in, pkt_vld, read_eb,
        input  busy, error, drop, data_out, vld_out
    );

    modport slave (
        input  data_in, pkt_vld, read_eb,
        output busy, error, drop, data_out, vld_out
    );
endinterface
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : router_fifo
//  Description : First-word-fall-through FIFO for one router channel.
//                rd_data shows the head word while non-empty, 0 when empty.
//                Ports: clk, rst (sync, active-high), wr_en/wr_data,
//                rd_en (ignored when empty), flush (empties the FIFO),
//                rd_data, full, empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               wr_en,
    input  wire  [DATA_W-1:0] wr_data,
    input  wire               rd_en,
    input  wire               flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    w_wr_base;
    logic              w_do_wr;
    logic              w_do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A flush empties the FIFO; a write in the same cycle lands in the
    // freshly emptied storage so a new header is never lost.
    assign w_do_wr = wr_en && (flush || !full);
    assign w_do_rd = rd_en && !empty && !flush;

    always_comb begin
        w_wr_base = flush ? '0 : wr_ptr_q;
        wr_ptr_d  = w_wr_base + {{PTR_W{1'b0}}, w_do_wr};
        rd_ptr_d  = flush ? '0 : rd_ptr_q + {{PTR_W{1'b0}}, w_do_rd};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[w_wr_base[PTR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/router_1xn.sv
`default_nettype none
// ============================================================================
//  Module      : router_1xn
//  Description : Parametrised 1-to-N byte-serial packet router. Packets
//                (header, LEN payload bytes, parity byte) are steered into
//                one of NUM_CH FWFT FIFOs by the header address; invalid
//                addresses are discarded with a drop pulse and parity
//                mismatches raise a sticky error.
//                Ports: clock, reset (sync, active-high), bus (slave modport
//                of router_1xn_if).
//                Optional build macro ROUTER_SOFT_RESET_EN: per-channel
//                stale-FIFO flush after TIMEOUT cycles without a read.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_1xn
    import router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input wire           clock,
    input wire           reset,
    router_1xn_if.slave  bus
);
    localparam int ADDR_W = addr_w_f(NUM_CH);
    localparam int LEN_W  = len_w_f(DATA_W, NUM_CH);
    // LEN+1 reaches 2^LEN_W, so one extra bit keeps the counter from wrapping.
    localparam int CNT_W  = LEN_W + 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   par_q, par_d;
    logic [DATA_W-1:0]   pbyte_q, pbyte_d;
    logic                error_q, error_d;
    logic                drop_q, drop_d;

    logic [ADDR_W-1:0]   w_hdr_addr;
    logic [LEN_W-1:0]    w_hdr_len;
    logic                w_hdr_ok;
    logic                w_hdr_full;
    logic                w_load_full;
    logic                w_load_flush;
    logic                w_busy;
    logic                w_accept;
    logic                w_wr_any;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [NUM_CH-1:0]   w_wr_en;
    logic [NUM_CH-1:0]   w_full;
    logic [NUM_CH-1:0]   w_empty;
    logic [NUM_CH-1:0]   w_flush;
    logic [DATA_W-1:0]   w_rd_data [NUM_CH];

    assign w_hdr_addr = bus.data_in[ADDR_W-1:0];
    assign w_hdr_len  = bus.data_in[DATA_W-1:ADDR_W];
    assign w_hdr_ok   = (32'(w_hdr_addr) < NUM_CH);
    assign w_wr_addr  = (state_q == IDLE) ? w_hdr_addr : addr_q;

    // Per-channel status selected by the header address (IDLE) and by the
    // latched address of the packet being loaded.
    always_comb begin
        w_hdr_full   = 1'b0;
        w_load_full  = 1'b0;
        w_load_flush = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_hdr_addr == ADDR_W'(c)) w_hdr_full = w_full[c];
            if (addr_q == ADDR_W'(c)) begin
                w_load_full  = w_full[c];
                w_load_flush = w_flush[c];
            end
        end
    end

    always_comb begin
        w_wr_en = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_wr_en[c] = w_wr_any && (w_wr_addr == ADDR_W'(c));
        end
    end

    // Full is sampled before any same-cycle pop, so a full FIFO being read
    // still stalls the source for that cycle.
    always_comb begin
        w_busy = 1'b0;
        case (state_q)
            IDLE:    w_busy = bus.pkt_vld && w_hdr_ok && w_hdr_full;
            LOAD:    w_busy = bus.pkt_vld && w_load_full;
            CHECK:   w_busy = 1'b1;
            DROP:    w_busy = 1'b0;
            default: w_busy = 1'b0;
        endcase
        if (reset) w_busy = 1'b0;
    end

    assign w_accept = bus.pkt_vld && !w_busy;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        pbyte_d  = pbyte_q;
        error_d  = error_q;
        drop_d   = 1'b0;
        w_wr_any = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    cnt_d = CNT_W'(w_hdr_len) + CNT_W'(1);
                    if (w_hdr_ok) begin
                        w_wr_any = 1'b1;
                        addr_d   = w_hdr_addr;
                        par_d    = bus.data_in;
                        error_d  = 1'b0;
                        state_d  = LOAD;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            LOAD: begin
                if (w_load_flush) begin
                    // Our FIFO is being flushed: discard the rest of the packet.
                    state_d = DROP;
                    if (w_accept) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) state_d = IDLE;
                    end
                end else if (w_accept) begin
                    w_wr_any = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        pbyte_d = bus.data_in;
                        state_d = CHECK;
                    end else begin
                        par_d = par_q ^ bus.data_in;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!w_load_flush) error_d = (par_q != pbyte_q);
            end
            DROP: begin
                if (w_accept) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            par_q   <= '0;
            pbyte_q <= '0;
            error_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            pbyte_q <= pbyte_d;
            error_q <= error_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.busy  = w_busy;
    assign bus.error = error_q;
    assign bus.drop  = drop_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        router_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clock),
            .rst     (reset),
            .wr_en   (w_wr_en[c]),
            .wr_data (bus.data_in),
            .rd_en   (bus.read_eb[c]),
            .flush   (w_flush[c]),
            .rd_data (w_rd_data[c]),
            .full    (w_full[c]),
            .empty   (w_empty[c])
        );
        assign bus.data_out[c*DATA_W +: DATA_W] = w_rd_data[c];
        assign bus.vld_out[c]                   = ~w_empty[c];
    end

`ifdef ROUTER_SOFT_RESET_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_tmo
        logic [TMO_W-1:0] tmo_q, tmo_d;

        // Counts cycles a non-empty FIFO goes unread; restarts on any read,
        // when empty, and on the flush itself.
        always_comb begin
            if (w_empty[c] || bus.read_eb[c] || w_flush[c]) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        always_ff @(posedge clock) begin
            if (reset) tmo_q <= '0;
            else       tmo_q <= tmo_d;
        end

        assign w_flush[c] = (32'(tmo_q) == TIMEOUT);
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_flush          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_1xn.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_1xn
//  Description : Directed self-checking bench for router_1xn with a
//                per-channel scoreboard of expected FIFO contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_1xn;
    localparam int DATA_W     = 8;
    localparam int NUM_CH     = 3;
    localparam int FIFO_DEPTH = 16;
    localparam int TIMEOUT    = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;

    router_1xn_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    router_1xn #(
        .DATA_W     (DATA_W),
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int drop_cnt = 0;
    logic [7:0] exp_q [NUM_CH][$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.drop === 1'b1) drop_cnt <= drop_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=stuck required=done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until accepted; push to the scoreboard
    // of channel ch when ch >= 0.
    task automatic send(input logic [7:0] b, input int ch);
        int n = 0;
        bus.data_in = b;
        bus.pkt_vld = 1'b1;
        #1;
        while (bus.busy !== 1'b0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_wait", 32'(n < 300), 1);
        @(posedge clk); #1;
        bus.pkt_vld = 1'b0;
        if (ch >= 0) exp_q[ch].push_back(b);
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input int len, input logic [7:0] base,
                            input bit corrupt, input int ch);
        logic [7:0] p;
        logic [7:0] b;
        p = hdr;
        send(hdr, ch);
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            p = p ^ b;
            send(b, ch);
        end
        send(corrupt ? 8'h00 : p, ch);
    endtask

    task automatic pop(input int ch, input string tag);
        logic [7:0] e;
        check({tag, "_vld"}, 32'(bus.vld_out[ch]), 1);
        check({tag, "_sb"}, 32'(exp_q[ch].size() > 0), 1);
        e = (exp_q[ch].size() > 0) ? exp_q[ch].pop_front() : 8'h00;
        check(tag, 32'(bus.data_out[ch*DATA_W +: DATA_W]), 32'(e));
        bus.read_eb[ch] = 1'b1;
        @(posedge clk); #1;
        bus.read_eb[ch] = 1'b0;
    endtask

    task automatic drain(input int ch, input string tag);
        while (exp_q[ch].size() > 0) pop(ch, tag);
        check({tag, "_empty"}, 32'(bus.vld_out[ch]), 0);
    endtask

    int         d0;
    int         r0;
    int         n;
    logic [7:0] p;

    initial begin
        bus.data_in = 8'h11;
        bus.pkt_vld = 1'b1;
        bus.read_eb = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_busy",     32'(bus.busy),     0);
        check("rst_error",    32'(bus.error),    0);
        check("rst_drop",     32'(bus.drop),     0);
        check("rst_vld_out",  32'(bus.vld_out),  0);
        check("rst_data_out", 32'(bus.data_out), 0);
        bus.pkt_vld = 1'b0;
        rst = 1'b0;

        // Channel-1 packet
        d0 = drop_cnt;
        send(8'h11, 1);
        check("t1_vld_rise", 32'(bus.vld_out), 32'h2);
        send(8'h01, 1);
        send(8'h02, 1);
        send(8'h03, 1);
        send(8'h04, 1);
        send(8'h15, 1);
        @(posedge clk); #1;
        check("t1_error", 32'(bus.error), 0);
        check("t1_no_drop", 32'(drop_cnt - d0), 0);
        drain(1, "t1_pop");

        // Corrupted parity, then recovery on the next valid header
        send_pkt(8'h11, 4, 8'h01, 1'b1, 1);
        @(posedge clk); #1;
        check("t2_err_set", 32'(bus.error), 1);
        drain(1, "t2_pop");
        send(8'h00, 0);
        check("t2_err_clr", 32'(bus.error), 0);
        send(8'h00, 0);
        @(posedge clk); #1;
        check("t2_err_ok", 32'(bus.error), 0);
        drain(0, "t2b_pop");

        // Invalid address 3, LEN 2
        d0 = drop_cnt;
        send(8'h0B, -1);
        check("t3_drop_pulse", 32'(bus.drop), 1);
        send(8'h01, -1);
        check("t3_drop_low", 32'(bus.drop), 0);
        send(8'h02, -1);
        send(8'h08, -1);
        @(posedge clk); #1;
        check("t3_drop_once", 32'(drop_cnt - d0), 1);
        check("t3_no_vld", 32'(bus.vld_out), 0);
        check("t3_error", 32'(bus.error), 0);
        send_pkt(8'h06, 1, 8'hA0, 1'b0, 2);
        @(posedge clk); #1;
        check("t3_next_err", 32'(bus.error), 0);
        drain(2, "t3_pop");

        // Backpressure: channel 0, LEN 20, nothing read until FIFO full
        p = 8'h50;
        send(8'h50, 0);
        for (int i = 1; i <= 15; i++) begin
            send(8'(i), 0);
            p = p ^ 8'(i);
        end
        bus.data_in = 8'd16;
        bus.pkt_vld = 1'b1;
        #1;
        check("t4_busy_full", 32'(bus.busy), 1);
        @(posedge clk); #1;
        check("t4_busy_hold", 32'(bus.busy), 1);
        bus.read_eb[0] = 1'b1;
        #1;
        check("t4_busy_rdcycle", 32'(bus.busy), 1);
        check("t4_head", 32'(bus.data_out[7:0]), 32'(exp_q[0].pop_front()));
        @(posedge clk); #1;
        bus.read_eb[0] = 1'b0;
        check("t4_release", 32'(bus.busy), 0);
        @(posedge clk); #1;
        exp_q[0].push_back(8'd16);
        p = p ^ 8'd16;
        bus.data_in = 8'd17;
        #1;
        check("t4_one_only", 32'(bus.busy), 1);
        fork
            begin
                for (int i = 17; i <= 20; i++) begin
                    send(8'(i), 0);
                    p = p ^ 8'(i);
                end
                send(p, 0);
            end
            begin
                for (int k = 0; k < 21; k++) begin
                    n = 0;
                    while (bus.vld_out[0] !== 1'b1 && n < 50) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    pop(0, "t4_pop");
                end
            end
        join
        @(posedge clk); #1;
        check("t4_error", 32'(bus.error), 0);
        check("t4_empty", 32'(bus.vld_out), 0);
        check("t4_sb_empty", 32'(exp_q[0].size()), 0);

        // Stale FIFO on channel 2
        send(8'h02, 2);
        r0 = cyc;
        check("t5_vld_rise", 32'(bus.vld_out[2]), 1);
        send(8'h02, 2);
`ifdef ROUTER_SOFT_RESET_EN
        n = 0;
        while (bus.vld_out[2] === 1'b1 && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_flush_time", 32'(cyc - r0), 32'(TIMEOUT + 1));
        exp_q[2].delete();
        check("t5_flushed", 32'(bus.vld_out), 0);
`else
        repeat (TIMEOUT + 10) @(posedge clk);
        #1;
        check("t5_hold", 32'(bus.vld_out[2]), 1);
        drain(2, "t5_pop");
`endif

        // Reset in the middle of LOAD
        send(8'h11, 1);
        send(8'h01, 1);
        send(8'h02, 1);
        rst = 1'b1;
        bus.data_in = 8'h03;
        bus.pkt_vld = 1'b1;
        @(posedge clk); #1;
        check("t6_busy",     32'(bus.busy),     0);
        check("t6_error",    32'(bus.error),    0);
        check("t6_drop",     32'(bus.drop),     0);
        check("t6_vld_out",  32'(bus.vld_out),  0);
        check("t6_data_out", 32'(bus.data_out), 0);
        exp_q[1].delete();
        bus.pkt_vld = 1'b0;
        rst = 1'b0;
        send_pkt(8'h11, 4, 8'h01, 1'b0, 1);
        @(posedge clk); #1;
        check("t6_err_after", 32'(bus.error), 0);
        drain(1, "t6_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
